// File: rtl/counter_pkg.sv
// counter_pkg: constants shared by the counter family (up-counters and the
// down-counter/timer).
//   CNT_W              default counter width
//   CNT_IDLE, CNT_RUN  timer state encodings
//   cnt_state_t        enum built on those encodings
package counter_pkg;

  localparam int   CNT_W    = 4;
  localparam logic CNT_IDLE = 1'b0;
  localparam logic CNT_RUN  = 1'b1;

  typedef enum logic {
    ST_IDLE = CNT_IDLE,
    ST_RUN  = CNT_RUN
  } cnt_state_t;

endpackage

// File: rtl/counter_4bdown_timer.sv
// counter_4bdown_timer: loadable synchronous down-counter/timer.
// The counter is loaded with a count, and START begins counting down. When the
// count expires, TC goes high for one cycle. If AUTO is set, the counter
// reloads and keeps running, so it produces a periodic tick.
// Ports:
//   CLK    clock, posedge
//   RST    synchronous active-high reset
//   LOAD   load DIN into count and reload register (forces IDLE)
//   DIN    load value
//   START  begin counting from current Q (IDLE only)
//   EN     count enable; low pauses a running count
//   AUTO   reload on expiry instead of returning to IDLE
//   Q      current count
//   BUSY   high while running
//   TC     one-cycle terminal-count pulse
module counter_4bdown_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  input  logic             START,
  input  logic             EN,
  input  logic             AUTO,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             TC
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;     // TC is a pulse, so it clears unless it is set below
    if (LOAD) begin
      q_d      = DIN;
      reload_d = DIN;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (START) begin
            // A zero count means a zero-length timeout. It fires at once and
            // the counter stays in IDLE.
            if (q_q == ZERO) tc_d = 1'b1;
            else             state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (EN) begin
            if (q_q > ONE) begin
              q_d = q_q - ONE;
            end else if (q_q == ONE) begin
              tc_d = 1'b1;
              // A zero reload would give a run with no length, so it is
              // treated the same as AUTO=0.
              if (AUTO && reload_q != ZERO) begin
                q_d = reload_q;
              end else begin
                q_d     = ZERO;
                state_d = ST_IDLE;
              end
            end else begin
              // The state RUN with Q==0 is not reachable. It is recovered
              // here without a pulse.
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign Q    = q_q;
  assign BUSY = (state_q == ST_RUN);
  assign TC   = tc_q;

endmodule

// File: tb/tb_counter_4bdown_timer.sv
// tb_counter_4bdown_timer: directed test of counter_4bdown_timer. The expected
// values are worked out by hand. Inputs change 1 time unit after each posedge,
// and outputs are sampled at that point.
module tb_counter_4bdown_timer;

  logic       CLK = 1'b0;
  logic       RST, LOAD, START, EN, AUTO;
  logic [3:0] DIN;
  logic [3:0] Q;
  logic       BUSY, TC;

  int n_chk = 0;
  int n_err = 0;
  int cyc;

  counter_4bdown_timer #(.WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .DIN(DIN), .START(START),
    .EN(EN), .AUTO(AUTO), .Q(Q), .BUSY(BUSY), .TC(TC)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input int q, input int b, input int t);
    chk({tag, ".q"},    32'(Q),    q);
    chk({tag, ".busy"}, 32'(BUSY), b);
    chk({tag, ".tc"},   32'(TC),   t);
  endtask

  task automatic do_load(input logic [3:0] v);
    LOAD = 1'b1; DIN = v; tick(); LOAD = 1'b0;
  endtask

  initial begin
    RST = 1'b1; LOAD = 0; START = 0; EN = 0; AUTO = 0; DIN = 0;
    tick();
    chk_all("reset", 0, 0, 0);
    RST = 1'b0;

    // 1: reset while running, then a zero-length timeout
    do_load(4'd5);
    START = 1; EN = 0; tick(); START = 0;
    chk_all("t1.run", 5, 1, 0);
    RST = 1; tick(); RST = 0;
    chk_all("t1.rst", 0, 0, 0);
    START = 1; tick(); START = 0;
    chk_all("t1.zero", 0, 0, 1);
    tick();
    chk("t1.zero_end.tc", 32'(TC), 0);

    // 2: basic countdown 4,3,2,1,0
    EN = 1;
    do_load(4'd4);
    START = 1; tick(); START = 0;
    chk_all("t2.start", 4, 1, 0);
    for (int i = 3; i >= 1; i--) begin
      tick(); chk_all($sformatf("t2.cnt%0d", i), i, 1, 0);
    end
    tick(); chk_all("t2.expire", 0, 0, 1);
    tick(); chk_all("t2.after", 0, 0, 0);

    // 3: pause at Q=3 for 3 cycles; TC arrives 9 edges after START
    do_load(4'd6);
    START = 1; tick(); START = 0;
    cyc = 0;
    for (int i = 5; i >= 3; i--) begin
      tick(); cyc++; chk_all($sformatf("t3.cnt%0d", i), i, 1, 0);
    end
    EN = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); cyc++; chk_all($sformatf("t3.hold%0d", i), 3, 1, 0);
    end
    EN = 1;
    while (TC !== 1'b1 && cyc < 20) begin
      tick(); cyc++;
    end
    chk("t3.delay", 32'(cyc), 9);
    chk_all("t3.expire", 0, 0, 1);

    // 4: auto-reload period 3, then period 1
    AUTO = 1;
    do_load(4'd3);
    START = 1; tick(); START = 0;
    chk_all("t4.start", 3, 1, 0);
    for (int p = 0; p < 2; p++) begin
      tick(); chk_all($sformatf("t4.p%0d.2", p), 2, 1, 0);
      tick(); chk_all($sformatf("t4.p%0d.1", p), 1, 1, 0);
      tick(); chk_all($sformatf("t4.p%0d.rl", p), 3, 1, 1);
    end
    do_load(4'd1);
    chk_all("t4.ld1", 1, 0, 0);
    START = 1; tick(); START = 0;
    chk_all("t4.st1", 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all($sformatf("t4.tick%0d", i), 1, 1, 1);
    end
    AUTO = 0;
    tick(); chk_all("t4.stop", 0, 0, 1);
    tick(); chk("t4.stop_end.tc", 32'(TC), 0);

    // 5: LOAD wins over expiry; LOAD+START stays IDLE
    do_load(4'd2);
    START = 1; tick(); START = 0;
    tick(); chk_all("t5.q1", 1, 1, 0);
    do_load(4'd9);
    chk_all("t5.ld_exp", 9, 0, 0);
    LOAD = 1; START = 1; DIN = 4'd7; tick(); LOAD = 0; START = 0;
    chk_all("t5.ld_st", 7, 0, 0);
    tick(); chk_all("t5.idle", 7, 0, 0);

    // 6: full-range count 15..0; START while RUN is ignored; no wrap
    do_load(4'd15);
    START = 1; tick(); START = 0;
    chk_all("t6.start", 15, 1, 0);
    for (int i = 14; i >= 1; i--) begin
      START = (i >= 8 && i <= 10);
      tick(); chk_all($sformatf("t6.cnt%0d", i), i, 1, 0);
    end
    START = 0;
    tick(); chk_all("t6.expire", 0, 0, 1);
    tick(); chk_all("t6.nowrap", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
